// File: rtl/lda_pkg.sv
// rtl/lda_pkg.sv - shared types and sizing helpers for the one-vs-one LDA classifier
package lda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_VOTE,
    ST_OUT
  } state_e;

  function automatic int ndisc(input int c);
    return c * (c - 1) / 2;
  endfunction

  function automatic int accw(input int dw, input int dims);
    return 2 * dw + $clog2(dims) + 1;
  endfunction

  function automatic int cfg_aw(input int c, input int dims);
    return $clog2(ndisc(c) * (dims + 1));
  endfunction

  localparam int COEF_W = 16;
  typedef logic signed [COEF_W-1:0] coef_t;

endpackage

// File: rtl/lda_ovo_seq_if.sv
// rtl/lda_ovo_seq_if.sv - feature/result handshakes and coefficient write port
interface lda_ovo_seq_if
  import lda_pkg::*;
#(
  parameter int DIMS    = 6,
  parameter int CLASSES = 3,
  parameter int DW      = 16
);
  localparam int AW = cfg_aw(CLASSES, DIMS);
  localparam int CW = $clog2(CLASSES);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic signed [DW-1:0] in_data_i [DIMS];
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [CLASSES-1:0]   out_class_o;
  logic [CW-1:0]        out_idx_o;
  logic                 cfg_we_i;
  logic [AW-1:0]        cfg_addr_i;
  logic signed [DW-1:0] cfg_wdata_i;
  logic                 cfg_err_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output in_ready_o, out_valid_o, out_class_o, out_idx_o, cfg_err_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  in_ready_o, out_valid_o, out_class_o, out_idx_o, cfg_err_o
  );
endinterface

// File: rtl/lda_mac.sv
// rtl/lda_mac.sv - signed multiply-accumulate with clear; sum_o includes the current product
module lda_mac #(
  parameter int DW   = 16,
  parameter int ACCW = 36
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [ACCW-1:0] sum_o
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_q, acc_d;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

  // clr_i wins so the last term of a discriminant is compared, then dropped
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = clr_i ? '0 : sum_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/lda_ovo_seq.sv
// rtl/lda_ovo_seq.sv - time-multiplexed one-vs-one LDA classifier with majority vote
module lda_ovo_seq
  import lda_pkg::*;
#(
  parameter int DIMS    = 6,
  parameter int CLASSES = 3,
  parameter int DW      = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  lda_ovo_seq_if.slave bus
);
  localparam int NDISC = ndisc(CLASSES);
  localparam int ACCW  = accw(DW, DIMS);
  localparam int NW    = NDISC * DIMS;
  localparam int IW    = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int KW    = (NDISC > 1) ? $clog2(NDISC) : 1;
  localparam int WIW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW    = $clog2(CLASSES);
  localparam int VW    = $clog2(CLASSES) + 1;

  state_e state_q, state_d;

  logic signed [DW-1:0] x_q   [DIMS];
  logic signed [DW-1:0] w_q   [NW];
  logic signed [DW-1:0] thr_q [NDISC];
  logic [VW-1:0]        votes_q [CLASSES];

  logic [IW-1:0]      i_q;
  logic [KW-1:0]      k_q;
  logic [WIW-1:0]     widx_q;
  logic [CW-1:0]      a_q, b_q;
  logic [CLASSES-1:0] class_q, class_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [VW-1:0]      best_v;
  logic               err_q;

  logic accept, out_fire, mac_en, last_dim, last_pair, cfg_ok;
  logic signed [ACCW-1:0] sum, thr_ext;

  assign accept    = (state_q == ST_IDLE) && bus.in_valid_i;
  assign out_fire  = (state_q == ST_OUT) && bus.out_ready_i;
  assign mac_en    = (state_q == ST_MAC);
  assign last_dim  = (i_q == IW'(DIMS - 1));
  assign last_pair = (a_q == CW'(CLASSES - 2)) && (b_q == CW'(CLASSES - 1));
  assign thr_ext   = {{(ACCW-DW){thr_q[k_q][DW-1]}}, thr_q[k_q]};
  assign cfg_ok    = (state_q == ST_IDLE) && (int'(bus.cfg_addr_i) < NW + NDISC);

  lda_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mac_en),
    .clr_i (mac_en && last_dim),
    .a_i   (x_q[i_q]),
    .b_i   (w_q[widx_q]),
    .sum_o (sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid_i) state_d = ST_MAC;
      ST_MAC:  if (last_dim && last_pair) state_d = ST_VOTE;
      ST_VOTE: state_d = ST_OUT;
      ST_OUT:  if (bus.out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // strict compare keeps the lowest index on ties
  always_comb begin
    idx_d  = '0;
    best_v = votes_q[0];
    for (int c = 1; c < CLASSES; c++) begin
      if (votes_q[c] > best_v) begin
        best_v = votes_q[c];
        idx_d  = CW'(c);
      end
    end
    class_d = {{(CLASSES-1){1'b0}}, 1'b1} << idx_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_q <= bus.in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q     <= '0;
      k_q     <= '0;
      widx_q  <= '0;
      a_q     <= '0;
      b_q     <= CW'(1);
      class_q <= '0;
      idx_q   <= '0;
      for (int c = 0; c < CLASSES; c++) votes_q[c] <= '0;
    end else begin
      if (accept) begin
        i_q    <= '0;
        k_q    <= '0;
        widx_q <= '0;
        a_q    <= '0;
        b_q    <= CW'(1);
      end
      if (mac_en) begin
        widx_q <= widx_q + WIW'(1);
        if (last_dim) begin
          i_q <= '0;
          k_q <= k_q + KW'(1);
          if (sum > thr_ext) votes_q[b_q] <= votes_q[b_q] + VW'(1);
          else               votes_q[a_q] <= votes_q[a_q] + VW'(1);
          // lexicographic pair walk: (a,a+1)..(a,C-1) then (a+1,a+2)
          if (b_q == CW'(CLASSES - 1)) begin
            a_q <= a_q + CW'(1);
            b_q <= a_q + CW'(2);
          end else begin
            b_q <= b_q + CW'(1);
          end
        end else begin
          i_q <= i_q + IW'(1);
        end
      end
      if (state_q == ST_VOTE) begin
        class_q <= class_d;
        idx_q   <= idx_d;
      end
      if (out_fire) begin
        for (int c = 0; c < CLASSES; c++) votes_q[c] <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      for (int n = 0; n < NW; n++) w_q[n] <= '0;
      for (int n = 0; n < NDISC; n++) thr_q[n] <= '0;
    end else begin
      err_q <= bus.cfg_we_i && !cfg_ok;
      if (bus.cfg_we_i && cfg_ok) begin
        for (int n = 0; n < NW; n++) begin
          if (int'(bus.cfg_addr_i) == n) w_q[n] <= bus.cfg_wdata_i;
        end
        for (int n = 0; n < NDISC; n++) begin
          if (int'(bus.cfg_addr_i) == NW + n) thr_q[n] <= bus.cfg_wdata_i;
        end
      end
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_OUT);
  assign bus.out_class_o = class_q;
  assign bus.out_idx_o   = idx_q;
  assign bus.cfg_err_o   = err_q;
endmodule

// File: doc/lda_ovo_seq.md
Name: lda_ovo_seq

Overview:
Time-multiplexed, parametrised one-vs-one LDA classifier for the olfactory sensor front end. Accepts a DIMS-wide signed feature vector over a valid/ready handshake and evaluates NDISC = CLASSES*(CLASSES-1)/2 pairwise linear discriminants on a single shared multiply-accumulate, one product per cycle. It then majority-votes and returns the winning class over a second valid/ready handshake. Weights and thresholds sit in an internal register file loaded through a simple config write port.

Parameters:
DIMS, 6, feature vector length (>=1)
CLASSES, 3, number of classes (>=2); NDISC = CLASSES*(CLASSES-1)/2 derived
DW, 16, signed width of features, weights and thresholds
ACCW, 2*DW+$clog2(DIMS)+1, derived accumulator width; never overridden

Ports:
clk_i  in  1  clock; all logic rising-edge
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  feature vector valid
in_ready_o  out  1  block can accept a vector
in_data_i  in  DW x DIMS  signed features, unpacked array
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
out_class_o  out  CLASSES  one-hot winning class
out_idx_o  out  $clog2(CLASSES)  winning class index
cfg_we_i  in  1  coefficient write strobe
cfg_addr_i  in  $clog2(NDISC*(DIMS+1))  coefficient address
cfg_wdata_i  in  DW  signed coefficient
cfg_err_o  out  1  one-cycle pulse: write ignored

Behaviour:
- Reset: state IDLE; in_ready_o=1; out_valid_o=0; out_class_o=0; out_idx_o=0; cfg_err_o=0; all weights, thresholds, accumulator and vote counters = 0. Reset mid-operation aborts the current vector; no result is produced.
- Pair order: discriminant k maps to pair (a,b), a<b, in lexicographic order: (0,1),(0,2),...,(0,C-1),(1,2),... The design generates a,b with counters, not a table.
- Address map: addr k*DIMS+i = weight(k,i); addr NDISC*DIMS+k = threshold(k). Out-of-range address: write ignored, cfg_err_o pulses.
- Config writes take effect only in IDLE. A write in any other state is ignored and cfg_err_o pulses the following cycle.
- FSM IDLE -> MAC -> VOTE -> OUT -> IDLE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o (cycle 0), the block captures in_data_i into an internal register and goes to MAC. In all other states in_ready_o=0.
- MAC: NDISC*DIMS cycles, cycles 1..NDISC*DIMS. Each cycle: acc += x[i]*w(k,i), signed, full precision, no saturation (ACCW cannot overflow).
- On i=DIMS-1 the block compares the final sum against sign-extended threshold(k). If sum > thr (strict), votes[b]++; else votes[a]++. The accumulator then clears for k+1.
- VOTE: one cycle. Argmax of votes; ties go to the lowest class index. Results are registered.
- OUT: out_valid_o=1 from cycle NDISC*DIMS+2 (20 at defaults). out_class_o and out_idx_o are held stable while out_valid_o && !out_ready_i.
- Handshake in OUT clears out_valid_o and votes and returns to IDLE. No new vector is accepted in that same cycle.
- Throughput: one vector per NDISC*DIMS+3 cycles plus backpressure.
- out_class_o is always one-hot or zero (zero only after reset).

Decomposition:
- Package lda_pkg:
  - state enum typedef
  - functions ndisc(C), accw(DW,DIMS), cfg address width
  - signed coefficient typedef parameterised by DW through a function-free localparam pattern
- Sub-module lda_mac: signed DW x DW multiply, ACCW accumulate, clear and enable inputs, combinational sum-out for the compare.
- The FSM, pair counters, vote counters and coefficient register file live in lda_ovo_seq.

Test Plan:
1. Reset, no config; send din=all 7 -> in_ready_o drops at cycle 1; out_valid_o rises at cycle 20; out_class_o=3'b001, out_idx_o=0 (all scores 0, not > 0).
2. Load weight(0,0)=1, all else 0; din[0]=5 -> votes {1,2,0} -> out_class_o=3'b010, out_idx_o=1.
3. Signed: weight(1,0)=-1, threshold(1)=-50; din[0]=100 -> score -100 not > -50, vote 0. Repeat with din[0]=10 -> -10 > -50, vote class 2. Check out_class_o for both cases.
4. Tie: weight(1,0)=1, weight(2,0)=-1, thresholds 0, din[0]=5 -> pair (0,1) votes 0, pair (0,2) votes 2, pair (1,2) votes 1 -> three-way tie -> out_class_o=3'b001.
5. Backpressure:
   - out_ready_i=0 for 10 cycles -> outputs stable, in_ready_o=0, in_valid_i held high not accepted.
   - out_ready_i=1 -> next cycle IDLE, second vector accepted.
6. Extremes and control:
   - din=-32768 and all weights -32768 -> score 6*2^30, no wrap, > any threshold.
   - cfg write during MAC -> ignored, cfg_err_o=1 for one cycle.
   - rst_i pulsed at cycle 8 -> IDLE next cycle, out_valid_o stays 0, coefficients read back as 0 via the test 1 result.
